path_walker_10x10: RTL and testbench

PATH_WALKER_10X10 -- requirements
Module: path_walker_10x10

---
 rtl/path_walker_10x10.sv | 216 +++++++++++++++++++++
 tb/tb_path_walker_10x10.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/path_walker_10x10.sv
// path_walker_10x10: walks a 10x10 maze from a start cell toward the goal by
// descending a precomputed BFS distance table one cell at a time. Each chosen
// step is offered on a valid/ready handshake and applied only when accepted.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   walk_en                  level request to walk; deassertion aborts
//   start_row, start_col     start cell, latched when a walk begins
//   maze[0:99]               wall map (1 = wall), index = row*10+col
//   dist_table[0:99]         distance to goal per cell, 127 = unreachable
//   dist_done                distance table valid (checked only at walk start)
//   step_valid/step_ready    step handshake; step_dir 0=UP 1=DOWN 2=LEFT 3=RIGHT
//   cur_row, cur_col         current walker position
//   step_count               accepted steps in this walk
//   walk_done, walk_fail     terminal status, held until walk_en drops
module path_walker_10x10 #(
    parameter logic [3:0] GOAL_ROW  = 4'd0,
    parameter logic [3:0] GOAL_COL  = 4'd9,
    parameter logic [6:0] MAX_STEPS = 7'd99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       walk_en,
    input  logic [3:0] start_row,
    input  logic [3:0] start_col,
    input  logic       maze       [0:99],
    input  logic [6:0] dist_table [0:99],
    input  logic       dist_done,
    output logic       step_valid,
    input  logic       step_ready,
    output logic [1:0] step_dir,
    output logic [3:0] cur_row,
    output logic [3:0] cur_col,
    output logic [6:0] step_count,
    output logic       walk_done,
    output logic       walk_fail
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_PICK  = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [6:0] DIST_INF = 7'd127;

    logic [2:0] r_state, w_state_nxt;
    logic [3:0] r_row, w_row_nxt;
    logic [3:0] r_col, w_col_nxt;
    logic [6:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_dir, w_dir_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_done, w_done_nxt;
    logic       r_fail, w_fail_nxt;

    logic       w_in_bounds;
    logic [6:0] w_cur_idx;
    logic       w_cur_wall;
    logic [6:0] w_cur_dist;
    logic [6:0] w_tgt_dist;
    logic [3:0] w_nb_ok;   // bit per direction: neighbour is a legal downhill move
    logic [6:0] w_nb_idx;

    // Current-cell lookup; index forced to 0 when off-grid so it is never out of range
    always_comb begin
        w_in_bounds = (r_row <= 4'd9) && (r_col <= 4'd9);
        w_cur_idx   = w_in_bounds ? 7'(7'(r_row) * 7'd10 + 7'(r_col)) : 7'd0;
        w_cur_wall  = maze[w_cur_idx];
        w_cur_dist  = dist_table[w_cur_idx];
        w_tgt_dist  = w_cur_dist - 7'd1;
    end

    // Neighbour qualification; an index is formed only for moves that stay on-grid
    always_comb begin
        w_nb_ok  = 4'b0000;
        w_nb_idx = 7'd0;
        if (w_in_bounds && r_row != 4'd0) begin
            w_nb_idx   = w_cur_idx - 7'd10;
            w_nb_ok[0] = !maze[w_nb_idx] && (dist_table[w_nb_idx] == w_tgt_dist);
        end
        if (w_in_bounds && r_row != 4'd9) begin
            w_nb_idx   = w_cur_idx + 7'd10;
            w_nb_ok[1] = !maze[w_nb_idx] && (dist_table[w_nb_idx] == w_tgt_dist);
        end
        if (w_in_bounds && r_col != 4'd0) begin
            w_nb_idx   = w_cur_idx - 7'd1;
            w_nb_ok[2] = !maze[w_nb_idx] && (dist_table[w_nb_idx] == w_tgt_dist);
        end
        if (w_in_bounds && r_col != 4'd9) begin
            w_nb_idx   = w_cur_idx + 7'd1;
            w_nb_ok[3] = !maze[w_nb_idx] && (dist_table[w_nb_idx] == w_tgt_dist);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (walk_en && dist_done) begin
                    w_row_nxt   = start_row;
                    w_col_nxt   = start_col;
                    w_cnt_nxt   = 7'd0;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!walk_en) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_in_bounds || w_cur_wall || w_cur_dist == DIST_INF) begin
                    w_state_nxt = S_FAIL;
                    w_fail_nxt  = 1'b1;
                end else if (w_cur_dist == 7'd0) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == MAX_STEPS) begin
                    w_state_nxt = S_FAIL;
                    w_fail_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_PICK;
                end
            end
            S_PICK: begin
                if (!walk_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_nb_ok == 4'b0000) begin
                    w_state_nxt = S_FAIL;
                    w_fail_nxt  = 1'b1;
                end else begin
                    if (w_nb_ok[0])      w_dir_nxt = DIR_UP;
                    else if (w_nb_ok[1]) w_dir_nxt = DIR_DOWN;
                    else if (w_nb_ok[2]) w_dir_nxt = DIR_LEFT;
                    else                 w_dir_nxt = DIR_RIGHT;
                    w_state_nxt = S_EMIT;
                    w_valid_nxt = 1'b1;
                end
            end
            S_EMIT: begin
                if (!walk_en) begin
                    w_state_nxt = S_IDLE;
                end else if (step_ready) begin
                    case (r_dir)
                        DIR_UP:   w_row_nxt = r_row - 4'd1;
                        DIR_DOWN: w_row_nxt = r_row + 4'd1;
                        DIR_LEFT: w_col_nxt = r_col - 4'd1;
                        default:  w_col_nxt = r_col + 4'd1;
                    endcase
                    w_cnt_nxt   = r_cnt + 7'd1;
                    w_state_nxt = S_CHECK;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            S_DONE: begin
                if (!walk_en) w_state_nxt = S_IDLE;
                else          w_done_nxt  = 1'b1;
            end
            S_FAIL: begin
                if (!walk_en) w_state_nxt = S_IDLE;
                else          w_fail_nxt  = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= 4'd0;
            r_col   <= 4'd0;
            r_cnt   <= 7'd0;
            r_dir   <= 2'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    // Distance 0 anywhere but the goal means the table came from a producer with another goal
    always_ff @(posedge clk) begin
        if (r_state == S_CHECK && w_in_bounds && !w_cur_wall && w_cur_dist == 7'd0)
            assert (r_row == GOAL_ROW && r_col == GOAL_COL);
    end

    assign step_valid = r_valid;
    assign step_dir   = r_dir;
    assign cur_row    = r_row;
    assign cur_col    = r_col;
    assign step_count = r_cnt;
    assign walk_done  = r_done;
    assign walk_fail  = r_fail;

endmodule

// File: tb/tb_path_walker_10x10.sv
// tb_path_walker_10x10: directed bench for path_walker_10x10 on an open 10x10
// maze with goal (0,9) and a Manhattan distance table, plus wall, unreachable,
// off-grid, corrupted-table, stall, abort and mid-walk reset scenarios.
module tb_path_walker_10x10;

    logic       clk;
    logic       rst_n;
    logic       walk_en;
    logic [3:0] start_row;
    logic [3:0] start_col;
    logic       maze       [0:99];
    logic [6:0] dist_table [0:99];
    logic       dist_done;
    logic       step_valid;
    logic       step_ready;
    logic [1:0] step_dir;
    logic [3:0] cur_row;
    logic [3:0] cur_col;
    logic [6:0] step_count;
    logic       walk_done;
    logic       walk_fail;

    int n_chk;
    int n_pass;

    // Cumulative handshake/offer counters kept by the monitor
    int mon_dir [0:3];
    int mon_valid;

    path_walker_10x10 u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .walk_en    (walk_en),
        .start_row  (start_row),
        .start_col  (start_col),
        .maze       (maze),
        .dist_table (dist_table),
        .dist_done  (dist_done),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step_dir   (step_dir),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .step_count (step_count),
        .walk_done  (walk_done),
        .walk_fail  (walk_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle monitor: a valid seen with ready high is accepted at the next rising edge
    initial begin
        for (int d = 0; d < 4; d++) mon_dir[d] = 0;
        mon_valid = 0;
    end
    always @(negedge clk) begin
        if (rst_n && step_valid) begin
            mon_valid = mon_valid + 1;
            if (step_ready) mon_dir[step_dir] = mon_dir[step_dir] + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk = n_chk + 1;
        if (obs == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_term(input string tag);
        bit got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            step();
            if (walk_done || walk_fail) got = 1'b1;
        end
        chk({tag, "_term"}, int'(got), 1);
    endtask

    task automatic wait_valid(input string tag);
        bit got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            step();
            if (step_valid) got = 1'b1;
        end
        chk({tag, "_valid"}, int'(got), 1);
    endtask

    // Return to IDLE, snapshot counters, then request a walk from (r,c)
    int b_dir [0:3];
    int b_valid;
    task automatic begin_walk(input logic [3:0] r, input logic [3:0] c);
        walk_en = 1'b0;
        step();
        step();
        for (int d = 0; d < 4; d++) b_dir[d] = mon_dir[d];
        b_valid   = mon_valid;
        start_row = r;
        start_col = c;
        walk_en   = 1'b1;
    endtask

    function automatic int d_dir(input int d);
        return mon_dir[d] - b_dir[d];
    endfunction

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        walk_en    = 1'b0;
        step_ready = 1'b1;
        dist_done  = 1'b0;
        start_row  = 4'd0;
        start_col  = 4'd0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) begin
                maze[r*10+c]       = 1'b0;
                dist_table[r*10+c] = 7'(r + (9 - c));
            end

        repeat (3) step();
        chk("rst_valid", int'(step_valid), 0);
        chk("rst_dir",   int'(step_dir),   0);
        chk("rst_row",   int'(cur_row),    0);
        chk("rst_col",   int'(cur_col),    0);
        chk("rst_cnt",   int'(step_count), 0);
        chk("rst_done",  int'(walk_done),  0);
        chk("rst_fail",  int'(walk_fail),  0);
        rst_n     = 1'b1;
        dist_done = 1'b1;
        step();

        // (0,0): nine RIGHT steps to the goal
        begin_walk(4'd0, 4'd0);
        wait_term("w00");
        chk("w00_right", d_dir(3), 9);
        chk("w00_other", d_dir(0) + d_dir(1) + d_dir(2), 0);
        chk("w00_cnt",   int'(step_count), 9);
        chk("w00_done",  int'(walk_done), 1);
        chk("w00_fail",  int'(walk_fail), 0);
        chk("w00_pos",   int'({cur_row, cur_col}), 8'h09);

        // (9,9): nine UP steps
        begin_walk(4'd9, 4'd9);
        wait_term("w99");
        chk("w99_up",    d_dir(0), 9);
        chk("w99_other", d_dir(1) + d_dir(2) + d_dir(3), 0);
        chk("w99_cnt",   int'(step_count), 9);
        chk("w99_done",  int'(walk_done), 1);

        // walk_en low returns to IDLE and clears status
        walk_en = 1'b0;
        step();
        chk("idle_done", int'(walk_done), 0);

        // start on goal: done immediately with no step offered
        begin_walk(4'd0, 4'd9);
        wait_term("w09");
        chk("w09_done",  int'(walk_done), 1);
        chk("w09_cnt",   int'(step_count), 0);
        chk("w09_noval", mon_valid - b_valid, 0);

        // start on a wall
        maze[55] = 1'b1;
        begin_walk(4'd5, 4'd5);
        wait_term("wall");
        chk("wall_fail",  int'(walk_fail), 1);
        chk("wall_done",  int'(walk_done), 0);
        chk("wall_noval", mon_valid - b_valid, 0);
        maze[55] = 1'b0;

        // start off-grid
        begin_walk(4'd10, 4'd0);
        wait_term("oob");
        chk("oob_fail",  int'(walk_fail), 1);
        chk("oob_noval", mon_valid - b_valid, 0);

        // start on an unreachable cell
        dist_table[22] = 7'd127;
        begin_walk(4'd2, 4'd2);
        wait_term("inf");
        chk("inf_fail",  int'(walk_fail), 1);
        chk("inf_noval", mon_valid - b_valid, 0);
        dist_table[22] = 7'd9;

        // (0,5) corrupted to 5: from (0,2) two steps reach (0,4) then no neighbour at 4
        dist_table[5] = 7'd5;
        begin_walk(4'd0, 4'd2);
        wait_term("bad");
        chk("bad_fail", int'(walk_fail), 1);
        chk("bad_cnt",  int'(step_count), 2);
        chk("bad_pos",  int'({cur_row, cur_col}), 8'h04);
        dist_table[5] = 7'd4;

        // stall: ready low for 5 cycles while a RIGHT step from (0,0) is offered
        step_ready = 1'b0;
        begin_walk(4'd0, 4'd0);
        wait_valid("stl");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stl_valid", int'(step_valid), 1);
            chk("stl_dir",   int'(step_dir),   3);
            chk("stl_pos",   int'({cur_row, cur_col}), 8'h00);
        end
        chk("stl_cnt0", int'(step_count), 0);
        step_ready = 1'b1;
        step();
        step_ready = 1'b0;
        repeat (4) step();
        chk("stl_cnt1",  int'(step_count), 1);
        chk("stl_pos1",  int'({cur_row, cur_col}), 8'h01);
        chk("stl_acc",   d_dir(3), 1);
        chk("stl_valid2", int'(step_valid), 1);

        // abort in EMIT: IDLE next cycle, position and count kept
        walk_en = 1'b0;
        step();
        chk("abt_valid", int'(step_valid), 0);
        chk("abt_cnt",   int'(step_count), 1);
        chk("abt_pos",   int'({cur_row, cur_col}), 8'h01);
        chk("abt_term",  int'(walk_done | walk_fail), 0);

        // asynchronous reset during EMIT clears every output before the next edge
        begin_walk(4'd9, 4'd9);
        wait_valid("rst");
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", int'(step_valid), 0);
        chk("mrst_dir",   int'(step_dir),   0);
        chk("mrst_pos",   int'({cur_row, cur_col}), 0);
        chk("mrst_cnt",   int'(step_count), 0);
        chk("mrst_term",  int'(walk_done | walk_fail), 0);
        walk_en = 1'b0;
        step();
        rst_n = 1'b1;
        b_valid = mon_valid;
        repeat (4) step();
        chk("mrst_noval", mon_valid - b_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
